mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/mem_load_ext.sv | 24 ++
 rtl/mem_lsu.sv | 126 ++++++++++++
 tb/tb_mem_lsu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM states,
// byte-enable patterns and small decode helpers used by the top level.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  // Illegal width code, unsigned-width store, or misaligned half/word.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = addr_lo[0];
      F3_W:    e = (addr_lo != 2'b00);
      F3_BU:   e = we;
      F3_HU:   e = we | addr_lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Byte strobes for a store of the given width, aligned to lane 0.
  function automatic logic [3:0] store_be(input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      F3_B:    be = BE_B;
      F3_H:    be = BE_H;
      F3_W:    be = BE_W;
      default: be = BE_NONE;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-data extension: picks the low byte/half/word of the raw
// SRAM read word and sign- or zero-extends it according to funct3.
module mem_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Select width and extension kind; unknown codes yield zero.
  always_comb begin
    ext = 32'd0;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   ext = {24'd0, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   ext = {16'd0, raw[15:0]};
      F3_W:    ext = raw;
      default: ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a byte-addressed SRAM.
// Each request walks IDLE -> ACCESS -> RESP; the SRAM is driven only during
// the one-cycle ACCESS state and the response is held until consumed.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_write_data,
  input  logic [31:0]       sram_read_data
);

  lsu_state_t        state_r;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              err_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;
  logic [3:0]        w_en_s;
  logic [31:0]       ext_s;
  logic              unused_addr_s;

  // Upper address bits are intentionally dropped.
  assign unused_addr_s = ^req_addr[31:ADDR_W];

  mem_load_ext u_load_ext (
    .funct3 (funct3_r),
    .raw    (sram_read_data),
    .ext    (ext_s)
  );

  // Request FSM: capture on accept, sample SRAM in ACCESS, hold response in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      err_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            we_r        <= req_we;
            funct3_r    <= req_funct3;
            addr_r      <= req_addr[ADDR_W-1:0];
            wdata_r     <= req_wdata;
            err_r       <= access_err(req_we, req_funct3, req_addr[1:0]);
            req_ready_r <= 1'b0;
            state_r     <= ST_ACCESS;
          end else begin
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Stores and faulting requests return zero data.
          resp_rdata_r <= (we_r || err_r) ? 32'd0 : ext_s;
          resp_err_r   <= err_r;
          resp_valid_r <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            state_r      <= ST_RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Write strobes: only a clean store in ACCESS, and masked by reset that same cycle.
  always_comb begin
    w_en_s = BE_NONE;
    if (!rst && (state_r == ST_ACCESS) && we_r && !err_r) begin
      w_en_s = store_be(funct3_r);
    end else begin
      w_en_s = BE_NONE;
    end
  end

  assign req_ready       = req_ready_r;
  assign resp_valid      = resp_valid_r;
  assign resp_rdata      = resp_rdata_r;
  assign resp_err        = resp_err_r;
  assign sram_w_en       = w_en_s;
  assign sram_address    = addr_r;
  assign sram_write_data = wdata_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural byte-array SRAM and a
// response scoreboard queue filled when each request is driven.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  logic [7:0] mem [0:65535];
  logic       mem_init = 1'b0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .sram_w_en       (sram_w_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data)
  );

  // SRAM: pattern fill on the first falling edge, then byte-strobed writes on falling edges.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      mem_init <= 1'b1;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (sram_w_en[l]) mem[16'(sram_address + 16'(l))] <= sram_write_data[8*l +: 8];
      end
    end
  end

  assign sram_read_data = {mem[16'(sram_address + 16'd3)], mem[16'(sram_address + 16'd2)],
                           mem[16'(sram_address + 16'd1)], mem[sram_address]};

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic [15:0] a, input logic [7:0] exp);
    check(tag, {24'd0, mem[a]}, {24'd0, exp});
  endtask

  // One full request/response transaction with optional response back-pressure.
  task automatic transact(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [3:0] exp_wen, input logic [15:0] exp_sa,
                          input int hold);
    logic [32:0] exp_e;
    logic [3:0]  wen_seen;
    int          n;
    @(negedge clk);
    check({name, ":req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = 1'b0;
    sb_q.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    wen_seen = sram_w_en;
    check({name, ":access_no_valid"}, {31'd0, resp_valid}, 32'd0);
    check({name, ":access_ready"}, {31'd0, req_ready}, 32'd0);
    check({name, ":sram_addr"}, {16'd0, sram_address}, {16'd0, exp_sa});
    @(negedge clk);
    wen_seen = wen_seen | sram_w_en;
    check({name, ":latency"}, {31'd0, resp_valid}, 32'd1);
    n = 0;
    while (resp_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      wen_seen = wen_seen | sram_w_en;
      n++;
    end
    check({name, ":sb_depth"}, 32'(sb_q.size()), 32'd1);
    exp_e = (sb_q.size() > 0) ? sb_q.pop_front() : 33'd0;
    check({name, ":rdata"}, resp_rdata, exp_e[31:0]);
    check({name, ":err"}, {31'd0, resp_err}, {31'd0, exp_e[32]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      wen_seen = wen_seen | sram_w_en;
      check({name, ":hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({name, ":hold_rdata"}, resp_rdata, exp_e[31:0]);
      check({name, ":hold_err"}, {31'd0, resp_err}, {31'd0, exp_e[32]});
      check({name, ":hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    wen_seen = wen_seen | sram_w_en;
    check({name, ":post_valid"}, {31'd0, resp_valid}, 32'd0);
    check({name, ":post_err"}, {31'd0, resp_err}, 32'd0);
    check({name, ":post_ready"}, {31'd0, req_ready}, 32'd1);
    check({name, ":wen"}, {28'd0, wen_seen}, {28'd0, exp_wen});
  endtask

  // Guard against a hung DUT handshake.
  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    logic [3:0] wen_seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst:resp_err", {31'd0, resp_err}, 32'd0);
    check("rst:resp_rdata", resp_rdata, 32'd0);
    check("rst:sram_address", {16'd0, sram_address}, 32'd0);
    check("rst:sram_w_en", {28'd0, sram_w_en}, 32'd0);
    check("rst:req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;

    transact("sw_1000", 1'b1, F3_W, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 1'b0, 4'b1111, 16'h1000, 0);
    check_mem("mem_1000", 16'h1000, 8'hEF);
    check_mem("mem_1001", 16'h1001, 8'hBE);
    check_mem("mem_1002", 16'h1002, 8'hAD);
    check_mem("mem_1003", 16'h1003, 8'hDE);
    transact("lw_1000_hold", 1'b0, F3_W, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 16'h1000, 5);
    transact("lh_1002", 1'b0, F3_H, 32'h0000_1002, 32'd0, 32'hFFFF_DEAD, 1'b0, 4'b0000, 16'h1002, 0);
    transact("lhu_1000", 1'b0, F3_HU, 32'h0000_1000, 32'd0, 32'h0000_BEEF, 1'b0, 4'b0000, 16'h1000, 0);
    transact("sh_1000", 1'b1, F3_H, 32'h0000_1000, 32'hCAFE_1234, 32'd0, 1'b0, 4'b0011, 16'h1000, 1);
    transact("lw_1000_b", 1'b0, F3_W, 32'h0000_1000, 32'd0, 32'hDEAD_1234, 1'b0, 4'b0000, 16'h1000, 0);

    transact("sb_2003", 1'b1, F3_B, 32'h0000_2003, 32'h0000_0080, 32'd0, 1'b0, 4'b0001, 16'h2003, 0);
    check_mem("mem_2003", 16'h2003, 8'h80);
    check_mem("mem_2002", 16'h2002, init_byte(16'h2002));
    check_mem("mem_2004", 16'h2004, init_byte(16'h2004));
    transact("lb_2003", 1'b0, F3_B, 32'h0000_2003, 32'd0, 32'hFFFF_FF80, 1'b0, 4'b0000, 16'h2003, 0);
    transact("lbu_2003", 1'b0, F3_BU, 32'h0000_2003, 32'd0, 32'h0000_0080, 1'b0, 4'b0000, 16'h2003, 0);

    transact("lh_3001", 1'b0, F3_H, 32'h0000_3001, 32'd0, 32'd0, 1'b1, 4'b0000, 16'h3001, 0);
    transact("sw_3002", 1'b1, F3_W, 32'h0000_3002, 32'h1111_2222, 32'd0, 1'b1, 4'b0000, 16'h3002, 2);
    check_mem("mem_3002", 16'h3002, init_byte(16'h3002));
    check_mem("mem_3003", 16'h3003, init_byte(16'h3003));
    transact("sbu_store", 1'b1, F3_BU, 32'h0000_3010, 32'h0000_00FF, 32'd0, 1'b1, 4'b0000, 16'h3010, 0);
    check_mem("mem_3010", 16'h3010, init_byte(16'h3010));

    transact("sw_fffc", 1'b1, F3_W, 32'h0000_FFFC, 32'hA1B2_C3D4, 32'd0, 1'b0, 4'b1111, 16'hFFFC, 0);
    transact("lw_fffc", 1'b0, F3_W, 32'h0000_FFFC, 32'd0, 32'hA1B2_C3D4, 1'b0, 4'b0000, 16'hFFFC, 0);

    // Reset pulse while the store to 0x4000 is in ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h0000_4000; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    wen_seen = sram_w_en;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wen_seen = wen_seen | sram_w_en;
      check("rstacc:no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("rstacc:wen", {28'd0, wen_seen}, 32'd0);
    check("rstacc:req_ready", {31'd0, req_ready}, 32'd1);
    check("rstacc:state_idle", {30'd0, dut.state_r}, {30'd0, ST_IDLE});
    check_mem("rstacc:mem_4000", 16'h4000, init_byte(16'h4000));
    check_mem("rstacc:mem_4003", 16'h4003, init_byte(16'h4003));

    transact("f3_011", 1'b0, 3'b011, 32'h0000_5000, 32'd0, 32'd0, 1'b1, 4'b0000, 16'h5000, 0);
    transact("lw_10004", 1'b0, F3_W, 32'h0001_0004, 32'd0, 32'h5D5C_5F5E, 1'b0, 4'b0000, 16'h0004, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
